parity_stream_chk: RTL and testbench
====================================

PARITY_STREAM_CHK -- requirements
Module: parity_stream_chk

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: beat width in bits, legal range 1..256.
REQ-002 The block SHALL have parameter CNT_W, default 8: width of the fail counter.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port sel, input, 1 bit: check mode; 1 = odd check (pass when the packet holds an odd number of 1s), 0 = even check.
REQ-006 The block SHALL have port s_valid, input, 1 bit: input beat valid.
REQ-007 The block SHALL have port s_ready, output, 1 bit: input beat accepted when s_valid and s_ready are both 1.
REQ-008 The block SHALL have port s_data, input, DATA_W bits: beat payload.
REQ-009 The block SHALL have port s_last, input, 1 bit: the beat is the final beat of its packet.
REQ-010 The block SHALL have port m_valid, output, 1 bit: packet result pending.
REQ-011 The block SHALL have port m_ready, input, 1 bit: result consumed when m_valid and m_ready are both 1.
REQ-012 The block SHALL have port m_check, output, 1 bit: 1 = packet passed the selected check.
REQ-013 The block SHALL have port fail_cnt, output, CNT_W bits: count of failed packets.

Function
REQ-014 The block SHALL use a two-state FSM: IDLE (no packet open) and ACC (packet open).
REQ-015 Accepted beat in IDLE with s_last=0: acc <= ^s_data; mode_q <= sel; next state ACC.
REQ-016 Accepted beat in ACC with s_last=0: acc <= acc ^ (^s_data); state stays ACC.
REQ-017 Accepted beat with s_last=1 (from either state) SHALL close the packet: p = (prior acc, or 0 in IDLE) ^ (^s_data); mode m = mode_q in ACC, or sel in IDLE; m_check <= m ? p : ~p; m_valid <= 1; next state IDLE.
REQ-018 sel SHALL be sampled only on the first beat of a packet; sel changes while in ACC SHALL be ignored.
REQ-019 Latency SHALL be 1 cycle: m_valid rises on the clock edge that accepts the last beat.
REQ-020 m_valid and m_check SHALL hold stable until consumed; m_valid clears on consume unless a new last beat is accepted in the same cycle.
REQ-021 s_ready SHALL equal !m_valid || m_ready (combinational one-entry skid); non-last beats SHALL also obey s_ready.
REQ-022 Consume and a new last beat accepted in the same cycle SHALL load the new result with m_valid staying 1, and no result SHALL be lost.
REQ-023 A single-beat packet (s_last=1 in IDLE) SHALL be legal and SHALL use the current sel.
REQ-024 fail_cnt SHALL increment by 1 when a result with m_check=0 is loaded, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-025 Beats with s_valid=0 SHALL not change state, acc, or mode_q.

Reset
REQ-026 On rst_n=0, asynchronously: state=IDLE, acc=0, mode_q=0, m_valid=0, m_check=0, fail_cnt=0.
REQ-027 A reset asserted mid-packet SHALL discard the partial packet; the first accepted beat after release SHALL start a new packet.
REQ-028 s_ready SHALL be 1 during and immediately after reset.

Configuration
REQ-029 Macro PARITY_STREAM_FAIL_CNT_EN: when defined, fail_cnt SHALL behave per REQ-024; when undefined, the counter logic SHALL be omitted and fail_cnt SHALL be tied to 0 while the port is kept.

Verification
REQ-030 The bench SHALL cover: DATA_W=32, sel=1, single beat 0x0000_0007, last=1 -> next cycle m_valid=1, m_check=1, fail_cnt=0.
REQ-031 The bench SHALL cover: sel=0, beats 0x1, 0x3, 0x1(last) (four 1s) -> m_check=1; repeated with sel=1 -> m_check=0, fail_cnt=1.
REQ-032 The bench SHALL cover: sel=1 on beat 0, sel toggled to 0 on beats 1..2 of packet 0xF, 0x0, 0x1(last) -> odd mode used, m_check=1.
REQ-033 The bench SHALL cover: m_ready=0 for 5 cycles after a result -> s_ready=0, m_check stable; then m_ready=1 with a last beat accepted in the same cycle -> m_valid stays 1 and the new result is loaded.
REQ-034 The bench SHALL cover: rst_n pulsed low after 2 beats of a 4-beat packet -> all outputs reset at once; the following packet 0x1(last) with sel=1 -> m_check=1.
REQ-035 The bench SHALL cover: CNT_W=2, 5 failing packets -> fail_cnt saturates at 3; with the macro undefined -> fail_cnt=0 throughout.

Source files
------------

// File: rtl/parity_stream_chk.sv
// -----------------------------------------------------------------------------
// parity_stream_chk
//
// Streaming parity checker. Beats arrive on a valid/ready input stream and are
// grouped into packets by s_last. The parity of every 1 bit in the packet is
// accumulated. When the last beat is accepted, a one-entry result register is
// loaded with the pass/fail verdict:
//   sel = 1 : odd check, pass when the packet holds an odd number of 1s
//   sel = 0 : even check, pass when the packet holds an even number of 1s
// The mode is taken from the first beat of each packet only.
//
// Parameters
//   DATA_W  beat width in bits (1..256)
//   CNT_W   width of the failed-packet counter
//
// Ports
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   sel       check mode, sampled on the first beat of a packet
//   s_valid   input beat valid
//   s_ready   input beat ready (= !m_valid || m_ready)
//   s_data    beat payload
//   s_last    final beat of the packet
//   m_valid   result pending
//   m_ready   result consumed when m_valid && m_ready
//   m_check   1 = packet passed the selected check
//   fail_cnt  saturating count of failed packets
//
// Configuration macro
//   PARITY_STREAM_FAIL_CNT_EN  when defined, fail_cnt counts failed packets;
//                              when undefined, fail_cnt is tied to 0.
// -----------------------------------------------------------------------------
module parity_stream_chk #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_check,
  output logic [CNT_W-1:0]  fail_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic acc_q;
  logic mode_q;

  logic beat_acc;
  logic beat_par;
  logic pkt_par;
  logic pkt_mode;
  logic res_check;
  logic load_res;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (beat_acc && !s_last) state_d = ACC;
      ACC:  if (beat_acc && s_last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and packet-close datapath
  always_comb begin
    // One-entry skid: a new beat may enter whenever the result slot is empty
    // or is being drained in this same cycle.
    s_ready   = !m_valid || m_ready;
    beat_acc  = s_valid && s_ready;
    beat_par  = ^s_data;
    // In IDLE the closing beat is also the first beat, so no prior parity and
    // the live sel decides the mode.
    pkt_par   = ((state_q == ACC) ? acc_q : 1'b0) ^ beat_par;
    pkt_mode  = (state_q == ACC) ? mode_q : sel;
    res_check = pkt_mode ? pkt_par : ~pkt_par;
    load_res  = beat_acc && s_last;
  end

  // Running parity and latched mode of the open packet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= 1'b0;
      mode_q <= 1'b0;
    end else if (beat_acc && !s_last) begin
      if (state_q == IDLE) begin
        acc_q  <= beat_par;
        mode_q <= sel;
      end else begin
        acc_q  <= acc_q ^ beat_par;
      end
    end
  end

  // Result register; a load in the consume cycle takes priority so that
  // m_valid stays high and no verdict is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_check <= 1'b0;
    end else if (load_res) begin
      m_valid <= 1'b1;
      m_check <= res_check;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef PARITY_STREAM_FAIL_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_cnt <= '0;
    end else if (load_res && !res_check) begin
      fail_cnt <= sat_inc(fail_cnt);
    end
  end
`else
  assign fail_cnt = '0;
`endif

endmodule

// File: tb/tb_parity_stream_chk.sv
module tb_parity_stream_chk;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;
`ifdef PARITY_STREAM_FAIL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sel;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic              m_check;
  logic [CNT_W-1:0]  fail_cnt;

  always #5 clk = ~clk;

  parity_stream_chk #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_check(m_check), .fail_cnt(fail_cnt)
  );

  typedef struct packed {
    logic             chk;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Reference packet state
  bit m_open = 1'b0;
  bit m_par  = 1'b0;
  bit m_mode = 1'b0;
  int m_fail = 0;

  function automatic int exp_cnt(input int n);
    return CNT_EN ? n : 0;
  endfunction

  // Scoreboard drain: a transfer is observed on the negedge before its edge
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_pop: unexpected result m_check=%0b fail_cnt=%0d", m_check, fail_cnt);
      end else begin
        mon_e = sbq.pop_front();
        if (m_check !== mon_e.chk || fail_cnt !== mon_e.cnt) begin
          errors++;
          $display("FAIL sb_result: got check=%0b cnt=%0d, want check=%0b cnt=%0d",
                   m_check, fail_cnt, mon_e.chk, mon_e.cnt);
        end
      end
    end
  end

  task automatic model_accept(input logic [DATA_W-1:0] d, input logic l, input logic s);
    bit p;
    bit chk;
    p = ($countones(d) % 2) == 1;
    if (!m_open) begin
      m_mode = s;
      m_par  = 1'b0;
    end
    m_par = m_par ^ p;
    if (l) begin
      chk = m_mode ? m_par : ~m_par;
      if (!chk && CNT_EN && m_fail < 3) m_fail++;
      sbq.push_back({chk, m_fail[CNT_W-1:0]});
      m_open = 1'b0;
    end else begin
      m_open = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat until accepted; called and returns at posedge+1.
  task automatic beat(input logic [DATA_W-1:0] d, input logic l, input logic s,
                      input bit rnd = 1'b0);
    bit done = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    sel     = s;
    for (int i = 0; i < 50 && !done; i++) begin
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (s_ready) begin
        model_accept(d, l, s);
        done = 1'b1;
      end
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: beat 0x%08h never accepted", d);
    end
  endtask

  task automatic model_flush();
    sbq.delete();
    m_open = 1'b0;
    m_fail = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || m_check !== 1'b0 || fail_cnt !== '0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got v=%0b c=%0b cnt=%0d rdy=%0b, want 0 0 0 1",
               m_valid, m_check, fail_cnt, s_ready);
    end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%0b v=%0b, want 1 0", s_ready, m_valid);
    end
    step();
  endtask

  task automatic test_single_beat();
    beat(32'h0000_0007, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_check !== 1'b1 || fail_cnt !== 2'd0) begin
      errors++;
      $display("FAIL single_beat: got v=%0b c=%0b cnt=%0d, want 1 1 0", m_valid, m_check, fail_cnt);
    end
    step();
  endtask

  task automatic test_even_odd();
    beat(32'h1, 1'b0, 1'b0);
    beat(32'h3, 1'b0, 1'b0);
    beat(32'h1, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (m_check !== 1'b1) begin
      errors++;
      $display("FAIL even_pass: got m_check=%0b, want 1", m_check);
    end
    step();
    beat(32'h1, 1'b0, 1'b1);
    beat(32'h3, 1'b0, 1'b1);
    beat(32'h1, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (m_check !== 1'b0 || fail_cnt !== CNT_W'(exp_cnt(1))) begin
      errors++;
      $display("FAIL odd_fail: got c=%0b cnt=%0d, want 0 %0d", m_check, fail_cnt, exp_cnt(1));
    end
    step();
  endtask

  task automatic test_sel_sample();
    beat(32'hF, 1'b0, 1'b1);
    beat(32'h0, 1'b0, 1'b0);
    beat(32'h1, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (m_check !== 1'b1 || fail_cnt !== CNT_W'(exp_cnt(1))) begin
      errors++;
      $display("FAIL sel_sample: got c=%0b cnt=%0d, want 1 %0d", m_check, fail_cnt, exp_cnt(1));
    end
    step();
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    beat(32'h1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_check !== 1'b1) begin
        errors++;
        $display("FAIL stall_%0d: got rdy=%0b v=%0b c=%0b, want 0 1 1", i, s_ready, m_valid, m_check);
      end
      step();
    end
    m_ready = 1'b1;
    beat(32'h3, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_check !== 1'b0 || fail_cnt !== CNT_W'(exp_cnt(2))) begin
      errors++;
      $display("FAIL consume_load: got v=%0b c=%0b cnt=%0d, want 1 0 %0d",
               m_valid, m_check, fail_cnt, exp_cnt(2));
    end
    step();
  endtask

  task automatic test_reset_mid_packet();
    beat(32'h1, 1'b1, 1'b1);
    beat(32'h1, 1'b0, 1'b0);
    beat(32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_check !== 1'b0 || fail_cnt !== '0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: got v=%0b c=%0b cnt=%0d rdy=%0b, want 0 0 0 1",
               m_valid, m_check, fail_cnt, s_ready);
    end
    model_flush();
    step();
    rst_n = 1'b1;
    beat(32'h1, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_check !== 1'b1) begin
      errors++;
      $display("FAIL after_reset: got v=%0b c=%0b, want 1 1", m_valid, m_check);
    end
    step();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++) beat(32'h1, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (fail_cnt !== CNT_W'(exp_cnt(3)) || m_check !== 1'b0) begin
      errors++;
      $display("FAIL saturate: got cnt=%0d c=%0b, want %0d 0", fail_cnt, m_check, exp_cnt(3));
    end
    step();
  endtask

  task automatic test_random();
    int len;
    for (int p = 0; p < 30; p++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++)
        beat($urandom, 1'(b == len - 1), 1'($urandom_range(0, 1)), 1'b1);
    end
    m_ready = 1'b1;
    repeat (3) step();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results left, want 0", sbq.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_even_odd();
    test_sel_sample();
    test_backpressure();
    test_reset_mid_packet();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
